// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a first-word-fall-through RX FIFO and sticky error flags
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int Depth          = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       uart_rx_i,
  output logic [7:0]                 rx_rdata_o,
  output logic                       rx_rvalid_o,
  input  logic                       rx_rready_i,
  output logic [$clog2(Depth+1)-1:0] rx_depth_o,
  output logic                       frame_err_o,
  output logic                       overflow_o,
  input  logic                       err_clr_i
);
  localparam int ClocksPerBaud = ClockFrequency / BaudRate;
  localparam int HalfBaud      = ClocksPerBaud / 2;
  localparam int CntW          = $clog2(ClocksPerBaud);
  localparam int PtrW          = $clog2(Depth);
  localparam int DepthW        = $clog2(Depth + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic            rx_q1, rx_s, rx_prev;
  logic [1:0]      state;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [DepthW-1:0] count;
  logic half_hit, full_hit, stop_done, full, pop, push, ovf_set, ferr_set;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= uart_rx_i;
      rx_s    <= rx_q1;
      rx_prev <= rx_s;
    end
  end
  assign half_hit  = baud_cnt == CntW'(HalfBaud - 1);
  assign full_hit  = baud_cnt == CntW'(ClocksPerBaud - 1);
  assign stop_done = (state == STOP) & full_hit;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (rx_prev & ~rx_s) state <= START;
        end
        START: begin
          baud_cnt <= half_hit ? '0 : baud_cnt + CntW'(1);
          bit_cnt  <= '0;
          if (half_hit) state <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          baud_cnt <= full_hit ? '0 : baud_cnt + CntW'(1);
          if (full_hit) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        default: begin
          baud_cnt <= full_hit ? '0 : baud_cnt + CntW'(1);
          if (full_hit) state <= IDLE;
        end
      endcase
    end
  end
  assign full     = count == DepthW'(Depth);
  assign pop      = rx_rvalid_o & rx_rready_i;
  assign push     = stop_done & rx_s & (~full | pop);
  assign ovf_set  = stop_done & rx_s & full & ~pop;
  assign ferr_set = stop_done & ~rx_s;
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= shift;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop) rd_ptr <= rd_ptr + PtrW'(1);
      count       <= (push & ~pop) ? count + DepthW'(1) : (pop & ~push) ? count - DepthW'(1) : count;
      frame_err_o <= ferr_set | (frame_err_o & ~err_clr_i);
      overflow_o  <= ovf_set | (overflow_o & ~err_clr_i);
    end
  end
  assign rx_rvalid_o = count != '0;
  assign rx_rdata_o  = rx_rvalid_o ? mem[rd_ptr] : 8'h00;
  assign rx_depth_o  = count;
endmodule
